// File: rtl/bot_nav_pkg.sv
// Shared definitions for the line-following navigation controller:
// state encoding, Sensors bit positions and MotCtl field layout.
package bot_nav_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_TURN_L  = 3'd2,
        ST_TURN_R  = 3'd3,
        ST_SEARCH  = 3'd4,
        ST_BLOCKED = 3'd5,
        ST_LOST    = 3'd6
    } nav_state_e;

    localparam int SNS_PROX_L = 4;
    localparam int SNS_PROX_R = 3;
    localparam int SNS_LINE_L = 2;
    localparam int SNS_LINE_C = 1;
    localparam int SNS_LINE_R = 0;

    localparam int MOT_LM_SPD_LSB = 5;
    localparam int MOT_LM_DIR     = 4;
    localparam int MOT_RM_SPD_LSB = 1;
    localparam int MOT_RM_DIR     = 0;

    localparam logic [7:0] MOT_STOP = 8'h00;

    function automatic logic [7:0] mot_pack(input logic [2:0] lspd, input logic ldir,
                                            input logic [2:0] rspd, input logic rdir);
        logic [7:0] w;
        w = MOT_STOP;
        w[MOT_LM_SPD_LSB +: 3] = lspd;
        w[MOT_LM_DIR]          = ldir;
        w[MOT_RM_SPD_LSB +: 3] = rspd;
        w[MOT_RM_DIR]          = rdir;
        return w;
    endfunction

endpackage

// File: rtl/bot_nav_if.sv
// System-register bundle between the bot host and the navigation controller;
// the controller connects through the slave modport.
interface bot_nav_if;
    logic        upd_sysregs;
    logic [7:0]  Sensors;
    logic [7:0]  BotInfo;
    logic        Enable;
    logic [7:0]  MotCtl;
    logic [2:0]  NavState;
    logic [15:0] UpdCnt;
    logic        Fault;

    modport master (
        output upd_sysregs, Sensors, BotInfo, Enable,
        input  MotCtl, NavState, UpdCnt, Fault
    );

    modport slave (
        input  upd_sysregs, Sensors, BotInfo, Enable,
        output MotCtl, NavState, UpdCnt, Fault
    );
endinterface

// File: rtl/bot_upd_detect.sv
// Toggle detector: every level change of upd_sysregs is one update event,
// flagged on the edge where the new level is first sampled.
module bot_upd_detect (
    input  logic clk,
    input  logic reset,
    input  logic upd_sysregs,
    output logic upd_evt
);

    logic upd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_q <= 1'b0;
        end else begin
            upd_q <= upd_sysregs;
        end
    end

    assign upd_evt = upd_sysregs ^ upd_q;

endmodule

// File: rtl/bot_nav_ctl.sv
// Navigation controller: decides motor commands from line/proximity sensors
// on each update event. Optional watchdog enabled by BOT_NAV_WATCHDOG_EN.
module bot_nav_ctl
    import bot_nav_pkg::*;
#(
    parameter logic [2:0]  FWD_SPD      = 3'd5,
    parameter logic [2:0]  TURN_SPD     = 3'd1,
    parameter logic [2:0]  SEARCH_SPD   = 3'd2,
    parameter logic [7:0]  SEARCH_LIMIT = 8'd64,
    parameter logic [23:0] WDOG_CYCLES  = 24'd5_000_000
) (
    input logic     clk,
    input logic     reset,
    bot_nav_if.slave bus
);

    if (SEARCH_LIMIT == 8'd0) begin : g_bad_search_limit
        $error("SEARCH_LIMIT must be nonzero");
    end
    if (WDOG_CYCLES == 24'd0) begin : g_bad_wdog
        $error("WDOG_CYCLES must be nonzero");
    end

    logic        upd_evt;
    nav_state_e  state_q, state_d;
    logic [7:0]  mot_q, mot_d;
    logic [7:0]  srch_q, srch_d;
    logic [15:0] upd_cnt_q, upd_cnt_d;
    logic        prox;

    bot_upd_detect u_detect (
        .clk         (clk),
        .reset       (reset),
        .upd_sysregs (bus.upd_sysregs),
        .upd_evt     (upd_evt)
    );

    function automatic logic [7:0] mot_for(input nav_state_e s);
        case (s)
            ST_FOLLOW: return mot_pack(FWD_SPD, 1'b1, FWD_SPD, 1'b1);
            ST_TURN_L: return mot_pack(TURN_SPD, 1'b1, FWD_SPD, 1'b1);
            ST_TURN_R: return mot_pack(FWD_SPD, 1'b1, TURN_SPD, 1'b1);
            ST_SEARCH: return mot_pack(SEARCH_SPD, 1'b0, SEARCH_SPD, 1'b1);
            default:   return MOT_STOP;
        endcase
    endfunction

    assign prox = bus.Sensors[SNS_PROX_L] | bus.Sensors[SNS_PROX_R];

`ifdef BOT_NAV_WATCHDOG_EN
    logic [23:0] wdog_q, wdog_d;
    logic        fault_q, fault_d;
`endif

    always_comb begin
        state_d   = state_q;
        mot_d     = mot_q;
        srch_d    = srch_q;
        upd_cnt_d = upd_evt ? upd_cnt_q + 16'd1 : upd_cnt_q;

        // Enable=0 wins over any event; LOST ignores events until then
        if (!bus.Enable) begin
            state_d = ST_IDLE;
            srch_d  = 8'd0;
        end else if (upd_evt && state_q != ST_LOST) begin
            srch_d = 8'd0;
            if (prox) begin
                state_d = ST_BLOCKED;
            end else if (!bus.Sensors[SNS_LINE_C]) begin
                state_d = ST_FOLLOW;
            end else if (!bus.Sensors[SNS_LINE_L]) begin
                state_d = ST_TURN_L;
            end else if (!bus.Sensors[SNS_LINE_R]) begin
                state_d = ST_TURN_R;
            end else begin
                srch_d  = srch_q + 8'd1;
                state_d = (srch_d == SEARCH_LIMIT) ? ST_LOST : ST_SEARCH;
            end
        end
        if (!bus.Enable || (upd_evt && state_q != ST_LOST)) begin
            mot_d = mot_for(state_d);
        end

`ifdef BOT_NAV_WATCHDOG_EN
        wdog_d  = wdog_q;
        fault_d = fault_q;
        if (!bus.Enable || upd_evt) begin
            wdog_d  = 24'd0;
            fault_d = 1'b0;
        end else if (wdog_q != WDOG_CYCLES) begin
            wdog_d = wdog_q + 24'd1;
            if (wdog_d == WDOG_CYCLES) begin
                fault_d = 1'b1;
            end
        end
        if (fault_d) begin
            mot_d = MOT_STOP;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mot_q     <= MOT_STOP;
            srch_q    <= 8'd0;
            upd_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            mot_q     <= mot_d;
            srch_q    <= srch_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

`ifdef BOT_NAV_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q  <= 24'd0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign bus.Fault = fault_q;
`else
    assign bus.Fault = 1'b0;
`endif

    assign bus.MotCtl   = mot_q;
    assign bus.NavState = state_q;
    assign bus.UpdCnt   = upd_cnt_q;

endmodule
